// File: rtl/fifo_cfg_pkg.sv
// Shared configuration helpers for the width-converting FIFO.
// Provides narrow/wide width and ratio computation, the legal-ratio check,
// the level-counter width function and the packing-order encodings.
package fifo_cfg_pkg;

  localparam int PACK_LSB_FIRST = 0;
  localparam int PACK_MSB_FIRST = 1;

  function automatic int narrow_w(input int wr_w, input int rd_w);
    return (wr_w < rd_w) ? wr_w : rd_w;
  endfunction

  function automatic int wide_w(input int wr_w, input int rd_w);
    return (wr_w > rd_w) ? wr_w : rd_w;
  endfunction

  function automatic int ratio(input int wr_w, input int rd_w);
    return wide_w(wr_w, rd_w) / narrow_w(wr_w, rd_w);
  endfunction

  function automatic bit ratio_legal(input int wr_w, input int rd_w);
    int r;
    r = ratio(wr_w, rd_w);
    return ((wide_w(wr_w, rd_w) % narrow_w(wr_w, rd_w)) == 0) &&
           (r == 1 || r == 2 || r == 4 || r == 8);
  endfunction

  // Level counters hold 0..capacity inclusive, capacity in narrow units.
  function automatic int lvl_w(input int depth_w, input int wr_w, input int rd_w);
    return depth_w + $clog2(ratio(wr_w, rd_w)) + 1;
  endfunction

endpackage

// File: rtl/wconv_sdpram.sv
// Simple dual-port RAM, one write port and one read port with a registered
// (1-cycle) read. Only the read register is reset; array contents are not.
// Ports: clk_i/rst_i, write (we_i, waddr_i, wdata_i), read (re_i, raddr_i,
// rdata_o). rdata_o holds its value while re_i is low.
module wconv_sdpram #(
  parameter int W  = 16,
  parameter int AW = 10
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [2**AW];
  logic [W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/fifo_wconv_sync.sv
// Single-clock FIFO with write/read width conversion (ratio 1/2/4/8),
// optional first-word-fall-through and selectable packing order.
// Ports: clk/rst (async high), flush; write side wr_en/wr_data/wr_full/
// almost_full/af_thresh/wr_water_level/wr_overflow; read side rd_en/rd_data/
// rd_empty/almost_empty/ae_thresh/rd_water_level/rd_underflow.
//
// Two read-side cursors are kept: the pop cursor (rptr/rsub) frees storage
// and drives the levels; the fetch cursor (fptr/fsub) drives the RAM read.
// In standard mode they move together. In FWFT mode the fetch cursor runs
// one read word ahead, the RAM read register acting as the prefetch stage.
module fifo_wconv_sync
  import fifo_cfg_pkg::*;
#(
  parameter int WR_DATA_WIDTH = 8,
  parameter int RD_DATA_WIDTH = 16,
  parameter int DEPTH_WIDTH   = 10,
  parameter int FWFT          = 0,
  parameter int MSB_FIRST     = PACK_LSB_FIRST,
  localparam int LVL_W        = lvl_w(DEPTH_WIDTH, WR_DATA_WIDTH, RD_DATA_WIDTH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WR_DATA_WIDTH-1:0] wr_data,
  output logic                     wr_full,
  output logic                     almost_full,
  input  logic [LVL_W-1:0]         af_thresh,
  output logic [LVL_W-1:0]         wr_water_level,
  output logic                     wr_overflow,
  input  logic                     rd_en,
  output logic [RD_DATA_WIDTH-1:0] rd_data,
  output logic                     rd_empty,
  output logic                     almost_empty,
  input  logic [LVL_W-1:0]         ae_thresh,
  output logic [LVL_W-1:0]         rd_water_level,
  output logic                     rd_underflow
);

  localparam int WW    = wide_w(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int RATIO = ratio(WR_DATA_WIDTH, RD_DATA_WIDTH);
  localparam int WRR   = WW / WR_DATA_WIDTH;   // write words per slot
  localparam int RDR   = WW / RD_DATA_WIDTH;   // read words per slot
  localparam int WRB   = $clog2(WRR);
  localparam int RDB   = $clog2(RDR);
  localparam int CW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int PW    = DEPTH_WIDTH + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(WRR * (2**DEPTH_WIDTH));

  if (!ratio_legal(WR_DATA_WIDTH, RD_DATA_WIDTH)) begin : g_bad_ratio
    $error("fifo_wconv_sync: width ratio must be 1, 2, 4 or 8");
  end
  if (DEPTH_WIDTH < 4 || DEPTH_WIDTH > 16) begin : g_bad_depth
    $error("fifo_wconv_sync: DEPTH_WIDTH must be 4..16");
  end

  logic [PW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d, fptr_q, fptr_d;
  logic [CW-1:0]    pcnt_q, pcnt_d, rsub_q, rsub_d, fsub_q, fsub_d, sel_q, sel_d;
  logic [WW-1:0]    pack_q, pack_d, merged, ram_dout;
  logic             hv_q, hv_d, ovf_q, unf_q;
  logic [PW-1:0]    slots;
  logic [LVL_W-1:0] wr_lvl, rd_lvl;
  logic [CW-1:0]    wpos;
  logic             wr_acc, commit, pop, fetch;

  assign slots  = wptr_q - rptr_q;
  assign wr_lvl = (LVL_W'(slots) << WRB) + LVL_W'(pcnt_q);
  assign rd_lvl = (LVL_W'(slots) << RDB) - LVL_W'(rsub_q);

  assign wr_full  = (wr_lvl == FULL_LVL);
  assign rd_empty = (FWFT != 0) ? !hv_q : (rd_lvl == '0);

  assign wr_acc = wr_en && !wr_full && !flush;
  assign commit = wr_acc && (pcnt_q == CW'(WRR - 1));
  assign pop    = rd_en && !rd_empty && !flush;

  // FWFT: refill the head register whenever it is empty or being popped
  // and at least one further read word is committed behind it.
  always_comb begin
    if (FWFT != 0)
      fetch = !flush && (hv_q ? (pop && (rd_lvl > LVL_W'(1))) : (rd_lvl != '0));
    else
      fetch = pop;
  end

  // Merge the incoming narrow word into its packing position.
  assign wpos = (MSB_FIRST != 0) ? CW'(WRR - 1) - pcnt_q : pcnt_q;
  always_comb begin
    merged = pack_q;
    for (int i = 0; i < WRR; i++)
      if (int'(wpos) == i) merged[i*WR_DATA_WIDTH +: WR_DATA_WIDTH] = wr_data;
  end

  always_comb begin
    wptr_d = wptr_q; rptr_d = rptr_q; fptr_d = fptr_q;
    pcnt_d = pcnt_q; rsub_d = rsub_q; fsub_d = fsub_q;
    sel_d  = sel_q;  pack_d = pack_q; hv_d   = hv_q;
    if (flush) begin
      wptr_d = '0; rptr_d = '0; fptr_d = '0;
      pcnt_d = '0; rsub_d = '0; fsub_d = '0;
      pack_d = '0; hv_d   = 1'b0;
    end else begin
      if (wr_acc) begin
        pack_d = commit ? '0 : merged;
        pcnt_d = commit ? '0 : pcnt_q + CW'(1);
        if (commit) wptr_d = wptr_q + PW'(1);
      end
      if (pop) begin
        if (rsub_q == CW'(RDR - 1)) begin
          rsub_d = '0;
          rptr_d = rptr_q + PW'(1);
        end else begin
          rsub_d = rsub_q + CW'(1);
        end
      end
      if (fetch) begin
        // Remember which sub-word this fetch selects; the RAM output holds.
        sel_d = (MSB_FIRST != 0) ? CW'(RDR - 1) - fsub_q : fsub_q;
        if (fsub_q == CW'(RDR - 1)) begin
          fsub_d = '0;
          fptr_d = fptr_q + PW'(1);
        end else begin
          fsub_d = fsub_q + CW'(1);
        end
      end
      hv_d = fetch ? 1'b1 : (pop ? 1'b0 : hv_q);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0; rptr_q <= '0; fptr_q <= '0;
      pcnt_q <= '0; rsub_q <= '0; fsub_q <= '0;
      sel_q  <= '0; pack_q <= '0; hv_q   <= 1'b0;
      ovf_q  <= 1'b0; unf_q <= 1'b0;
    end else begin
      wptr_q <= wptr_d; rptr_q <= rptr_d; fptr_q <= fptr_d;
      pcnt_q <= pcnt_d; rsub_q <= rsub_d; fsub_q <= fsub_d;
      sel_q  <= sel_d;  pack_q <= pack_d; hv_q   <= hv_d;
      ovf_q  <= wr_en && wr_full && !flush;
      unf_q  <= rd_en && rd_empty && !flush;
    end
  end

  wconv_sdpram #(.W(WW), .AW(DEPTH_WIDTH)) u_ram (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (commit),
    .waddr_i (wptr_q[DEPTH_WIDTH-1:0]),
    .wdata_i (merged),
    .re_i    (fetch),
    .raddr_i (fptr_q[DEPTH_WIDTH-1:0]),
    .rdata_o (ram_dout)
  );

  always_comb begin
    rd_data = ram_dout[RD_DATA_WIDTH-1:0];
    for (int i = 0; i < RDR; i++)
      if (int'(sel_q) == i) rd_data = ram_dout[i*RD_DATA_WIDTH +: RD_DATA_WIDTH];
  end

  assign wr_water_level = wr_lvl;
  assign rd_water_level = rd_lvl;
  assign almost_full    = (wr_lvl >= af_thresh);
  assign almost_empty   = (rd_lvl <= ae_thresh);
  assign wr_overflow    = ovf_q;
  assign rd_underflow   = unf_q;

endmodule

// File: tb/tb_fifo_wconv_sync.sv
// Directed bench for fifo_wconv_sync. Four instances share clk/rst:
// A 8->16 LSB-first, B 8->16 MSB-first, C 32->8, D 8->8 FWFT (all depth 16).
module tb_fifo_wconv_sync;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Instance A
  logic a_fl, a_we, a_re, a_full, a_af, a_ovf, a_emp, a_ae, a_unf;
  logic [7:0] a_wd;  logic [15:0] a_rd;
  logic [5:0] a_aft, a_aet, a_wl, a_rl;
  // Instance B
  logic b_fl, b_we, b_re, b_full, b_af, b_ovf, b_emp, b_ae, b_unf;
  logic [7:0] b_wd;  logic [15:0] b_rd;
  logic [5:0] b_aft, b_aet, b_wl, b_rl;
  // Instance C
  logic c_fl, c_we, c_re, c_full, c_af, c_ovf, c_emp, c_ae, c_unf;
  logic [31:0] c_wd; logic [7:0] c_rd;
  logic [6:0] c_aft, c_aet, c_wl, c_rl;
  // Instance D
  logic d_fl, d_we, d_re, d_full, d_af, d_ovf, d_emp, d_ae, d_unf;
  logic [7:0] d_wd;  logic [7:0] d_rd;
  logic [4:0] d_aft, d_aet, d_wl, d_rl;

  fifo_wconv_sync #(.WR_DATA_WIDTH(8), .RD_DATA_WIDTH(16), .DEPTH_WIDTH(4),
                    .FWFT(0), .MSB_FIRST(0)) u_a (
    .clk(clk), .rst(rst), .flush(a_fl), .wr_en(a_we), .wr_data(a_wd),
    .wr_full(a_full), .almost_full(a_af), .af_thresh(a_aft), .wr_water_level(a_wl),
    .wr_overflow(a_ovf), .rd_en(a_re), .rd_data(a_rd), .rd_empty(a_emp),
    .almost_empty(a_ae), .ae_thresh(a_aet), .rd_water_level(a_rl), .rd_underflow(a_unf));

  fifo_wconv_sync #(.WR_DATA_WIDTH(8), .RD_DATA_WIDTH(16), .DEPTH_WIDTH(4),
                    .FWFT(0), .MSB_FIRST(1)) u_b (
    .clk(clk), .rst(rst), .flush(b_fl), .wr_en(b_we), .wr_data(b_wd),
    .wr_full(b_full), .almost_full(b_af), .af_thresh(b_aft), .wr_water_level(b_wl),
    .wr_overflow(b_ovf), .rd_en(b_re), .rd_data(b_rd), .rd_empty(b_emp),
    .almost_empty(b_ae), .ae_thresh(b_aet), .rd_water_level(b_rl), .rd_underflow(b_unf));

  fifo_wconv_sync #(.WR_DATA_WIDTH(32), .RD_DATA_WIDTH(8), .DEPTH_WIDTH(4),
                    .FWFT(0), .MSB_FIRST(0)) u_c (
    .clk(clk), .rst(rst), .flush(c_fl), .wr_en(c_we), .wr_data(c_wd),
    .wr_full(c_full), .almost_full(c_af), .af_thresh(c_aft), .wr_water_level(c_wl),
    .wr_overflow(c_ovf), .rd_en(c_re), .rd_data(c_rd), .rd_empty(c_emp),
    .almost_empty(c_ae), .ae_thresh(c_aet), .rd_water_level(c_rl), .rd_underflow(c_unf));

  fifo_wconv_sync #(.WR_DATA_WIDTH(8), .RD_DATA_WIDTH(8), .DEPTH_WIDTH(4),
                    .FWFT(1), .MSB_FIRST(0)) u_d (
    .clk(clk), .rst(rst), .flush(d_fl), .wr_en(d_we), .wr_data(d_wd),
    .wr_full(d_full), .almost_full(d_af), .af_thresh(d_aft), .wr_water_level(d_wl),
    .wr_overflow(d_ovf), .rd_en(d_re), .rd_data(d_rd), .rd_empty(d_emp),
    .almost_empty(d_ae), .ae_thresh(d_aet), .rd_water_level(d_rl), .rd_underflow(d_unf));

  initial begin
    logic [7:0] exp_c [4];
    exp_c[0] = 8'hDD; exp_c[1] = 8'hCC; exp_c[2] = 8'hBB; exp_c[3] = 8'hAA;

    a_fl = 0; a_we = 0; a_re = 0; a_wd = 0; a_aft = 6'd30; a_aet = 0;
    b_fl = 0; b_we = 0; b_re = 0; b_wd = 0; b_aft = 6'd30; b_aet = 0;
    c_fl = 0; c_we = 0; c_re = 0; c_wd = 0; c_aft = 0;     c_aet = 0;
    d_fl = 0; d_we = 0; d_re = 0; d_wd = 0; d_aft = 5'd16; d_aet = 0;

    // Reset values while rst is held
    #3;
    chk("rst_wlvl",  64'(a_wl),   64'(0));
    chk("rst_rlvl",  64'(a_rl),   64'(0));
    chk("rst_full",  64'(a_full), 64'(0));
    chk("rst_af",    64'(a_af),   64'(0));
    chk("rst_empty", 64'(a_emp),  64'(1));
    chk("rst_ae",    64'(a_ae),   64'(1));
    chk("rst_rdata", 64'(a_rd),   64'(0));
    chk("rst_ovf",   64'(a_ovf),  64'(0));
    chk("rst_unf",   64'(a_unf),  64'(0));
    chk("rst_empty_fwft", 64'(d_emp), 64'(1));
    #9 rst = 0;

    // Upsize packing: 0x11, 0x22 -> 0x2211 (LSB first) / 0x1122 (MSB first)
    a_we = 1; a_wd = 8'h11; b_we = 1; b_wd = 8'h11;
    tick();
    chk("up_empty_half", 64'(a_emp), 64'(1));
    chk("up_wlvl_half",  64'(a_wl),  64'(1));
    chk("up_rlvl_half",  64'(a_rl),  64'(0));
    a_wd = 8'h22; b_wd = 8'h22;
    tick();
    a_we = 0; b_we = 0;
    chk("up_empty_commit", 64'(a_emp), 64'(0));
    chk("up_wlvl", 64'(a_wl), 64'(2));
    chk("up_rlvl", 64'(a_rl), 64'(1));
    a_re = 1; b_re = 1;
    tick();
    a_re = 0; b_re = 0;
    chk("up_rdata_lsb", 64'(a_rd), 64'(16'h2211));
    chk("up_rdata_msb", 64'(b_rd), 64'(16'h1122));
    chk("up_empty_after", 64'(a_emp), 64'(1));

    // Flush over a half-packed word, with a concurrent write
    a_we = 1; a_wd = 8'h11;
    tick();
    chk("fl_pre_wlvl", 64'(a_wl), 64'(1));
    a_fl = 1; a_wd = 8'h99;
    tick();
    a_fl = 0; a_we = 0;
    chk("fl_wlvl", 64'(a_wl),  64'(0));
    chk("fl_rlvl", 64'(a_rl),  64'(0));
    chk("fl_ovf",  64'(a_ovf), 64'(0));
    a_we = 1; a_wd = 8'h33; tick();
    a_wd = 8'h44; tick();
    a_we = 0; a_re = 1; tick();
    a_re = 0;
    chk("fl_rdata", 64'(a_rd), 64'(16'h4433));

    // Downsize 32->8
    c_we = 1; c_wd = 32'hAABBCCDD;
    tick();
    c_we = 0;
    chk("dn_rlvl0", 64'(c_rl),  64'(4));
    chk("dn_wlvl0", 64'(c_wl),  64'(1));
    chk("dn_empty", 64'(c_emp), 64'(0));
    for (int k = 0; k < 4; k++) begin
      c_re = 1;
      tick();
      chk("dn_rdata", 64'(c_rd), 64'(exp_c[k]));
      chk("dn_rlvl",  64'(c_rl), 64'(3 - k));
      chk("dn_wlvl",  64'(c_wl), 64'((k < 3) ? 1 : 0));
    end
    c_re = 1;
    tick();
    c_re = 0;
    chk("dn_unf",       64'(c_unf), 64'(1));
    chk("dn_unf_hold",  64'(c_rd),  64'(8'hAA));
    chk("dn_unf_empty", 64'(c_emp), 64'(1));
    tick();
    chk("dn_unf_pulse", 64'(c_unf), 64'(0));

    // FWFT, ratio 1
    for (int i = 0; i < 5; i++) begin
      d_we = 1; d_wd = 8'(i + 1);
      tick();
      if (i == 0) chk("ff_empty_1cyc", 64'(d_emp), 64'(1));
      if (i == 1) begin
        chk("ff_empty_2cyc", 64'(d_emp), 64'(0));
        chk("ff_head",       64'(d_rd),  64'(1));
      end
    end
    d_we = 0;
    chk("ff_rlvl5", 64'(d_rl), 64'(5));
    chk("ff_wlvl5", 64'(d_wl), 64'(5));
    for (int i = 0; i < 20; i++) begin
      d_re = 1; d_we = 1; d_wd = 8'(i + 6);
      chk("ff_stream_data", 64'(d_rd), 64'(i + 1));
      tick();
      chk("ff_stream_rlvl", 64'(d_rl), 64'(5));
      chk("ff_stream_wlvl", 64'(d_wl), 64'(5));
    end
    d_re = 0; d_we = 0;
    chk("ff_head21", 64'(d_rd), 64'(21));
    d_aet = 5'd5; #1;
    chk("ff_ae_eq", 64'(d_ae), 64'(1));
    d_aet = 5'd4; #1;
    chk("ff_ae_below", 64'(d_ae), 64'(0));

    // Fill A to capacity, overflow, then one read
    tick();
    a_we = 1;
    for (int i = 0; i < 32; i++) begin
      a_wd = 8'(i);
      tick();
    end
    a_we = 0;
    chk("full_flag", 64'(a_full), 64'(1));
    chk("full_wlvl", 64'(a_wl),   64'(32));
    chk("full_af",   64'(a_af),   64'(1));
    a_we = 1; a_wd = 8'hEE;
    tick();
    a_we = 0;
    chk("ovf_pulse", 64'(a_ovf), 64'(1));
    chk("ovf_wlvl",  64'(a_wl),  64'(32));
    tick();
    chk("ovf_once",  64'(a_ovf), 64'(0));
    a_re = 1;
    tick();
    a_re = 0;
    chk("full_rd_wlvl",  64'(a_wl),   64'(30));
    chk("full_rd_data",  64'(a_rd),   64'(16'h0100));
    chk("full_rd_nfull", 64'(a_full), 64'(0));

    // Asynchronous reset in the middle of a write burst
    a_we = 1; a_wd = 8'h77;
    tick(); tick();
    #2 rst = 1;
    #1;
    chk("arst_wlvl",  64'(a_wl),  64'(0));
    chk("arst_rlvl",  64'(a_rl),  64'(0));
    chk("arst_empty", 64'(a_emp), 64'(1));
    chk("arst_rdata", 64'(a_rd),  64'(0));
    chk("arst_ae",    64'(a_ae),  64'(1));
    chk("arst_af",    64'(a_af),  64'(0));
    chk("arst_fwft_empty", 64'(d_emp), 64'(1));
    a_we = 0;
    #2 rst = 0;
    a_we = 1; a_wd = 8'h55;
    tick();
    a_wd = 8'h66;
    tick();
    a_we = 0;
    chk("arst_post_wlvl", 64'(a_wl), 64'(2));
    chk("arst_post_rlvl", 64'(a_rl), 64'(1));
    a_re = 1;
    tick();
    a_re = 0;
    chk("arst_post_rdata", 64'(a_rd), 64'(16'h6655));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
